// File: rtl/rvcore_pkg.sv
// Shared types for the RV32I pipeline control slice.
// Forwarding selects, controller state and tracker slot layout.
package rvcore_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    FAULT
  } pc_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_we;
    logic       is_load;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } trk_slot_t;

  function automatic logic writes(
    input trk_slot_t  s,
    input logic [4:0] r
  );
    return s.valid & s.reg_we & (s.rd == r) & (r != 5'd0);
  endfunction

  // Loads in MEM have no result yet, so only WB may forward them.
  function automatic logic [1:0] fwd_sel(
    input trk_slot_t  mem,
    input trk_slot_t  wb,
    input logic [4:0] r
  );
    if (writes(mem, r) && !mem.is_load) return FWD_EXMEM;
    if (writes(wb, r))                  return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_track.sv
// Private EX/MEM/WB destination tracker.
// Mirrors pipeline occupancy so hazard logic needs no datapath regs.
module hazard_track
  import rvcore_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      advance,
  input  logic      freeze,
  input  logic      bubble_ex,
  input  trk_slot_t id_slot,
  output trk_slot_t ex,
  output trk_slot_t mem,
  output trk_slot_t wb
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else if (freeze) begin
      wb  <= '0;
    end else if (advance) begin
      wb  <= mem;
      mem <= ex;
      ex  <= bubble_ex ? '0 : id_slot;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stalls, flushes, forwarding
// and the data-memory wait / timeout FSM.
module pipe_ctrl
  import rvcore_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_reg_we,
  input  logic       id_is_load,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_we,
  output logic       memwb_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       fault
);

  localparam int CW = $clog2(MEM_TIMEOUT) + 1;

  pc_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  trk_slot_t ex, mem, wb, id_slot;
  logic freeze, redirect, load_use, ld_hit;
  logic do_rst, do_frz, do_redir, do_lu;
  logic unused_ok;

  assign id_slot = '{valid: id_valid, rd: id_rd,
                     reg_we: id_reg_we, is_load: id_is_load,
                     rs1: id_rs1, rs2: id_rs2};

  assign freeze = (state == RUN && mem_req && !mem_ready)
               || (state == MEM_WAIT && !mem_ready)
               || (state == FAULT);

  assign ld_hit = ex.is_load
               && ((id_use_rs1 && writes(ex, id_rs1))
                || (id_use_rs2 && writes(ex, id_rs2)));

  assign redirect = ex_redirect && !freeze;
  assign load_use = id_valid && ld_hit && !redirect && !freeze;

  assign do_rst   = rst;
  assign do_frz   = !rst && freeze;
  assign do_redir = !rst && redirect;
  assign do_lu    = !rst && load_use;

  hazard_track u_trk (
    .clk       (clk),
    .rst       (rst),
    .advance   (!freeze),
    .freeze    (freeze),
    .bubble_ex (idex_flush),
    .id_slot   (id_slot),
    .ex        (ex),
    .mem       (mem),
    .wb        (wb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_nxt = MEM_WAIT;
          cnt_nxt   = CW'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(MEM_TIMEOUT - 1)) state_nxt = FAULT;
        end
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_we    = 1'b1;
    memwb_flush = 1'b0;
    unique case (1'b1)
      do_rst: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        exmem_we    = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        memwb_flush = 1'b1;
      end
      do_frz: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        exmem_we    = 1'b0;
        memwb_flush = 1'b1;
      end
      do_redir: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      do_lu: begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!rst && ex.valid) begin
      fwd_a = fwd_sel(mem, wb, ex.rs1);
      fwd_b = fwd_sel(mem, wb, ex.rs2);
    end
  end

  assign fault = !rst && (state == FAULT);

  assign unused_ok = ^{mem.rs1, mem.rs2, wb.rs1, wb.rs2, wb.is_load};

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (MEM_TIMEOUT = 4).
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       id_reg_we = 1'b0, id_is_load = 1'b0;
  logic       ex_redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic       pc_we, ifid_we, ifid_flush, idex_flush;
  logic       exmem_we, memwb_flush, fault;
  logic [1:0] fwd_a, fwd_b;
  logic [5:0] ctl;

  int n_chk = 0;
  int n_fail = 0;

  // {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_flush}
  localparam logic [5:0] NORM  = 6'b110010;
  localparam logic [5:0] FRZ   = 6'b000001;
  localparam logic [5:0] REDIR = 6'b111110;
  localparam logic [5:0] LU    = 6'b000110;
  localparam logic [5:0] RSTV  = 6'b001101;

  assign ctl = {pc_we, ifid_we, ifid_flush, idex_flush,
                exmem_we, memwb_flush};

  pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_reg_we   (id_reg_we),
    .id_is_load  (id_is_load),
    .ex_redirect (ex_redirect),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_we    (exmem_we),
    .memwb_flush (memwb_flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_id(input logic v, input logic [4:0] r1,
                        input logic [4:0] r2, input logic u1,
                        input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld);
    id_valid   = v;
    id_rs1     = r1;
    id_rs2     = r2;
    id_use_rs1 = u1;
    id_use_rs2 = u2;
    id_rd      = rd;
    id_reg_we  = we;
    id_is_load = ld;
  endtask

  task automatic nop;
    drv_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    ex_redirect = 1'b0;
    mem_req = 1'b0;
    mem_ready = 1'b0;
    nop();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    nop();
    tick();
    #1;
    n_chk++;
    if (ctl !== RSTV) begin
      n_fail++;
      $display("FAIL reset_ctl got %b exp %b", ctl, RSTV);
    end
    n_chk++;
    if ({fwd_a, fwd_b, fault} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_fwd_fault got %b exp 00000",
               {fwd_a, fwd_b, fault});
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (ctl !== NORM) begin
      n_fail++;
      $display("FAIL post_reset_ctl got %b exp %b", ctl, NORM);
    end
    tick();
  endtask

  task automatic test_load_use;
    do_reset();
    drv_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    #1;
    n_chk++;
    if (ctl !== NORM) begin
      n_fail++;
      $display("FAIL lu_lw_issue got %b exp %b", ctl, NORM);
    end
    tick();
    drv_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    n_chk++;
    if (ctl !== LU) begin
      n_fail++;
      $display("FAIL lu_stall got %b exp %b", ctl, LU);
    end
    tick();
    #1;
    n_chk++;
    if (ctl !== NORM) begin
      n_fail++;
      $display("FAIL lu_one_bubble got %b exp %b", ctl, NORM);
    end
    tick();
    nop();
    #1;
    n_chk++;
    if ({fwd_a, fwd_b} !== 4'b1000) begin
      n_fail++;
      $display("FAIL lu_fwd got %b exp 1000", {fwd_a, fwd_b});
    end
    tick();
  endtask

  task automatic test_alu_chain;
    do_reset();
    drv_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drv_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    #1;
    n_chk++;
    if (ctl !== NORM) begin
      n_fail++;
      $display("FAIL alu_no_stall got %b exp %b", ctl, NORM);
    end
    tick();
    nop();
    #1;
    n_chk++;
    if ({fwd_a, fwd_b} !== 4'b0101) begin
      n_fail++;
      $display("FAIL alu_fwd_mem got %b exp 0101", {fwd_a, fwd_b});
    end
    tick();
    do_reset();
    drv_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    drv_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    nop();
    #1;
    n_chk++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL alu_x0_fwd got %b exp 0000", {fwd_a, fwd_b});
    end
    tick();
    do_reset();
    drv_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    drv_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    nop();
    #1;
    n_chk++;
    if ({fwd_a, fwd_b} !== 4'b1010) begin
      n_fail++;
      $display("FAIL alu_fwd_wb got %b exp 1010", {fwd_a, fwd_b});
    end
    tick();
    do_reset();
    drv_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drv_id(1'b1, 5'd2, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drv_id(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    nop();
    #1;
    n_chk++;
    if ({fwd_a, fwd_b} !== 4'b0100) begin
      n_fail++;
      $display("FAIL alu_mem_priority got %b exp 0100",
               {fwd_a, fwd_b});
    end
    tick();
  endtask

  task automatic test_redirect_load_use;
    do_reset();
    drv_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    drv_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    ex_redirect = 1'b1;
    #1;
    n_chk++;
    if (ctl !== REDIR) begin
      n_fail++;
      $display("FAIL redir_over_lu got %b exp %b", ctl, REDIR);
    end
    tick();
    ex_redirect = 1'b0;
    #1;
    n_chk++;
    if (ctl !== NORM) begin
      n_fail++;
      $display("FAIL redir_ex_flushed got %b exp %b", ctl, NORM);
    end
    tick();
  endtask

  task automatic test_mem_wait;
    do_reset();
    nop();
    mem_req = 1'b1;
    mem_ready = 1'b1;
    #1;
    n_chk++;
    if (ctl !== NORM) begin
      n_fail++;
      $display("FAIL mem_ready_same_cycle got %b exp %b", ctl, NORM);
    end
    tick();
    mem_req = 1'b0;
    mem_ready = 1'b0;
    drv_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drv_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    nop();
    mem_req = 1'b1;
    ex_redirect = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      n_chk++;
      if (ctl !== FRZ || fwd_a !== 2'b01) begin
        n_fail++;
        $display("FAIL mem_freeze_%0d got %b/%b exp %b/01",
                 i, ctl, fwd_a, FRZ);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_chk++;
    if (ctl !== REDIR || fwd_a !== 2'b01) begin
      n_fail++;
      $display("FAIL mem_release_redir got %b/%b exp %b/01",
               ctl, fwd_a, REDIR);
    end
    tick();
    mem_req = 1'b0;
    mem_ready = 1'b0;
    ex_redirect = 1'b0;
    #1;
    n_chk++;
    if (ctl !== NORM || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_back_run got %b/%b exp %b/0",
               ctl, fault, NORM);
    end
    tick();
  endtask

  task automatic test_timeout;
    do_reset();
    mem_req = 1'b1;
    mem_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      n_chk++;
      if (fault !== (i >= 5) || ctl !== FRZ) begin
        n_fail++;
        $display("FAIL timeout_cyc%0d got %b/%b exp %b/%b",
                 i, fault, ctl, (i >= 5), FRZ);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (fault !== 1'b0 || ctl !== RSTV) begin
      n_fail++;
      $display("FAIL timeout_rst got %b/%b exp 0/%b",
               fault, ctl, RSTV);
    end
    tick();
    rst = 1'b0;
    mem_req = 1'b0;
    #1;
    n_chk++;
    if (fault !== 1'b0 || ctl !== NORM) begin
      n_fail++;
      $display("FAIL timeout_cleared got %b/%b exp 0/%b",
               fault, ctl, NORM);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait;
    do_reset();
    drv_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drv_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    nop();
    mem_req = 1'b1;
    mem_ready = 1'b0;
    #1;
    n_chk++;
    if (ctl !== FRZ || fwd_a !== 2'b01) begin
      n_fail++;
      $display("FAIL rmw_freeze got %b/%b exp %b/01",
               ctl, fwd_a, FRZ);
    end
    tick();
    rst = 1'b1;
    #1;
    n_chk++;
    if (ctl !== RSTV || {fwd_a, fwd_b, fault} !== 5'b00000) begin
      n_fail++;
      $display("FAIL rmw_forced got %b/%b exp %b/00000",
               ctl, {fwd_a, fwd_b, fault}, RSTV);
    end
    tick();
    rst = 1'b0;
    mem_req = 1'b0;
    drv_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    #1;
    n_chk++;
    if (ctl !== NORM || {fwd_a, fwd_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmw_empty got %b/%b exp %b/0000",
               ctl, {fwd_a, fwd_b}, NORM);
    end
    tick();
    nop();
    #1;
    n_chk++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmw_fwd_after got %b exp 0000",
               {fwd_a, fwd_b});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_chain();
    test_redirect_load_use();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
